inst_loader: RTL and testbench

- Writer-side counterpart to the pipeline's instruction decode path.
- Accepts symbolic instruction requests over a valid/ready stream and encodes each into a 32-bit MIPS word.
- Writes the words into instruction memory at consecutive word addresses, starting from a programmable base.
- Used by the debug/boot path to load programs before the CPU is released from reset.

---
 rtl/inst_loader_pkg.sv | 44 ++++
 rtl/inst_encoder.sv | 46 ++++
 rtl/inst_loader.sv | 155 +++++++++++++++
 tb/tb_inst_loader.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared MIPS encoding constants for the instruction loader.
//   LD_OP_*  : symbolic request codes carried on the loader's in_op field
//   INST_*   : MIPS primary opcode field values (bits 31:26)
//   R_FUNC_* : MIPS R-type funct field values (bits 5:0)
package inst_loader_pkg;

  // Request codes
  localparam logic [3:0] LD_OP_NOP  = 4'd0;
  localparam logic [3:0] LD_OP_ADD  = 4'd1;
  localparam logic [3:0] LD_OP_SUB  = 4'd2;
  localparam logic [3:0] LD_OP_AND  = 4'd3;
  localparam logic [3:0] LD_OP_OR   = 4'd4;
  localparam logic [3:0] LD_OP_SLT  = 4'd5;
  localparam logic [3:0] LD_OP_JR   = 4'd6;
  localparam logic [3:0] LD_OP_J    = 4'd7;
  localparam logic [3:0] LD_OP_JAL  = 4'd8;
  localparam logic [3:0] LD_OP_BEQ  = 4'd9;
  localparam logic [3:0] LD_OP_ADDI = 4'd10;
  localparam logic [3:0] LD_OP_ANDI = 4'd11;
  localparam logic [3:0] LD_OP_ORI  = 4'd12;
  localparam logic [3:0] LD_OP_LW   = 4'd13;
  localparam logic [3:0] LD_OP_SW   = 4'd14;
  localparam logic [3:0] LD_OP_ILL  = 4'd15;

  // Primary opcodes
  localparam logic [5:0] INST_RTYPE = 6'h00;
  localparam logic [5:0] INST_J     = 6'h02;
  localparam logic [5:0] INST_JAL   = 6'h03;
  localparam logic [5:0] INST_BEQ   = 6'h04;
  localparam logic [5:0] INST_ADDI  = 6'h08;
  localparam logic [5:0] INST_ANDI  = 6'h0C;
  localparam logic [5:0] INST_ORI   = 6'h0D;
  localparam logic [5:0] INST_LW    = 6'h23;
  localparam logic [5:0] INST_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] R_FUNC_ADD = 6'h20;
  localparam logic [5:0] R_FUNC_SUB = 6'h22;
  localparam logic [5:0] R_FUNC_AND = 6'h24;
  localparam logic [5:0] R_FUNC_OR  = 6'h25;
  localparam logic [5:0] R_FUNC_SLT = 6'h2A;
  localparam logic [5:0] R_FUNC_JR  = 6'h08;

endpackage

// File: rtl/inst_encoder.sv
// Combinational MIPS encoder: symbolic request -> 32-bit instruction word.
// Ports:
//   op_i      request code (LD_OP_*)
//   rs_i/rt_i/rd_i  register fields
//   imm_i     16-bit immediate, passed through untouched
//   target_i  26-bit jump target
//   word_o    encoded instruction (0 for illegal)
//   illegal_o high for LD_OP_ILL
module inst_encoder
  import inst_loader_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (op_i)
      LD_OP_NOP:  word_o = '0;
      LD_OP_ADD:  word_o = {INST_RTYPE, rs_i, rt_i, rd_i, 5'h00, R_FUNC_ADD};
      LD_OP_SUB:  word_o = {INST_RTYPE, rs_i, rt_i, rd_i, 5'h00, R_FUNC_SUB};
      LD_OP_AND:  word_o = {INST_RTYPE, rs_i, rt_i, rd_i, 5'h00, R_FUNC_AND};
      LD_OP_OR:   word_o = {INST_RTYPE, rs_i, rt_i, rd_i, 5'h00, R_FUNC_OR};
      LD_OP_SLT:  word_o = {INST_RTYPE, rs_i, rt_i, rd_i, 5'h00, R_FUNC_SLT};
      // JR only names rs; rt/rd are forced to zero.
      LD_OP_JR:   word_o = {INST_RTYPE, rs_i, 5'h00, 5'h00, 5'h00, R_FUNC_JR};
      LD_OP_J:    word_o = {INST_J, target_i};
      LD_OP_JAL:  word_o = {INST_JAL, target_i};
      LD_OP_BEQ:  word_o = {INST_BEQ, rs_i, rt_i, imm_i};
      LD_OP_ADDI: word_o = {INST_ADDI, rs_i, rt_i, imm_i};
      LD_OP_ANDI: word_o = {INST_ANDI, rs_i, rt_i, imm_i};
      LD_OP_ORI:  word_o = {INST_ORI, rs_i, rt_i, imm_i};
      LD_OP_LW:   word_o = {INST_LW, rs_i, rt_i, imm_i};
      LD_OP_SW:   word_o = {INST_SW, rs_i, rt_i, imm_i};
      default:    illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: encodes symbolic requests into MIPS words and writes
// them to instruction memory at consecutive addresses from a base.
// Handshakes: a request transfers on a clk edge where in_valid & in_ready;
// a memory write completes on an edge where imem_wen & imem_ack. Data and
// address are held stable while imem_wen is high without ack.
// Ports:
//   clk, rst (sync, active low)
//   start, base_addr          session control
//   in_valid/in_ready, in_*   request stream
//   imem_wen/addr/wdata/ack   memory write port
//   busy, done, err, count    status
//   dbg_state                 FSM state: 0 IDLE 1 ACCEPT 2 WRITE 3 DONE 4 ERROR
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [15:0]           in_imm,
  input  logic [25:0]           in_target,
  input  logic                  in_last,
  output logic                  imem_wen,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  input  logic                  imem_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   count,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WRITE  = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  // Count value meaning the whole memory has been written.
  localparam logic [ADDR_WIDTH:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [31:0] enc_word;
  logic        enc_illegal;

  inst_encoder u_enc (
    .op_i      (in_op),
    .rs_i      (in_rs),
    .rt_i      (in_rt),
    .rd_i      (in_rd),
    .imm_i     (in_imm),
    .target_i  (in_target),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    last_d  = last_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_ACCEPT;
          addr_d  = base_addr;
          count_d = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_ACCEPT: begin
        if (in_valid) begin
          if (enc_illegal) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            wdata_d = enc_word;
            last_d  = in_last;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (imem_ack) begin
          count_d = count_q + 1'b1;
          addr_d  = addr_q + 1'b1;
          // A last word that also fills memory is still a clean finish.
          if (last_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (count_d == CAP) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_ACCEPT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign in_ready   = (state_q == ST_ACCEPT);
  assign imem_wen   = (state_q == ST_WRITE);
  assign busy       = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
  assign done       = done_q;
  assign err        = err_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;
  import inst_loader_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (ADDR_WIDTH = 8)
  logic        start, in_valid, in_last, imem_ack;
  logic [7:0]  base_addr;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_ready, imem_wen, busy, done, err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  count;
  logic [2:0]  dbg_state;

  // small DUT (ADDR_WIDTH = 2) for overflow
  logic        start2, valid2, ack2;
  logic [1:0]  base2;
  logic        ready2, wen2, busy2, done2, err2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic [2:0]  count2;
  logic [2:0]  state2;

  inst_loader #(.ADDR_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last),
    .imem_wen(imem_wen), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_ack(imem_ack), .busy(busy), .done(done), .err(err),
    .count(count), .dbg_state(dbg_state)
  );

  inst_loader #(.ADDR_WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .base_addr(base2),
    .in_valid(valid2), .in_ready(ready2), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last),
    .imem_wen(wen2), .imem_addr(addr2), .imem_wdata(wdata2),
    .imem_ack(ack2), .busy(busy2), .done(done2), .err(err2),
    .count(count2), .dbg_state(state2)
  );

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad   = 0;
  logic [39:0] exp_q[$];   // {addr, word} expected in write order
  logic [7:0]  model_addr = 8'h00;
  int          model_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference encoder from the MIPS field layout.
  function automatic logic [31:0] ref_encode(input logic [3:0] op, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [4:0] rd,
                                             input logic [15:0] imm, input logic [25:0] tgt);
    logic [31:0] r_fields, i_fields;
    r_fields = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11);
    i_fields = (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    case (op)
      4'd1:  return r_fields | 32'h20;
      4'd2:  return r_fields | 32'h22;
      4'd3:  return r_fields | 32'h24;
      4'd4:  return r_fields | 32'h25;
      4'd5:  return r_fields | 32'h2A;
      4'd6:  return (32'(rs) << 21) | 32'h08;
      4'd7:  return (32'h02 << 26) | 32'(tgt);
      4'd8:  return (32'h03 << 26) | 32'(tgt);
      4'd9:  return (32'h04 << 26) | i_fields;
      4'd10: return (32'h08 << 26) | i_fields;
      4'd11: return (32'h0C << 26) | i_fields;
      4'd12: return (32'h0D << 26) | i_fields;
      4'd13: return (32'h23 << 26) | i_fields;
      4'd14: return (32'h2B << 26) | i_fields;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- compare process (main DUT) ----------------
  always @(negedge clk) begin
    if (rst) begin
      check("count", count, 64'(model_cnt));
      if (imem_wen) begin
        check("wen_vs_ready", in_ready, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          check("wr_addr", imem_addr, exp_q[0][39:32]);
          check("wr_data", imem_wdata, exp_q[0][31:0]);
          if (imem_ack) begin
            void'(exp_q.pop_front());
            model_cnt++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic do_start(input logic [7:0] b);
    start = 1'b1;
    base_addr = b;
    step();
    start = 1'b0;
    model_cnt = 0;
    model_addr = b;
    @(negedge clk);
    check("start_state", dbg_state, 3'd1);
    check("start_ready", in_ready, 1);
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_err", err, 0);
    step();
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input logic last, input logic [31:0] lit);
    bit ok;
    ok = 0;
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm = imm; in_target = tgt; in_last = last;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (op != LD_OP_ILL) begin
          exp_q.push_back({model_addr, ref_encode(op, rs, rt, rd, imm, tgt)});
          model_addr++;
        end
        ok = 1;
        break;
      end
      step();
    end
    check("handshake", ok, 1);
    step();
    in_valid = 1'b0;
    if (ok && op != LD_OP_ILL) begin
      @(negedge clk);
      check("lit_word", imem_wdata, lit);
      check("lit_wen", imem_wen, 1);
      check("lit_ready", in_ready, 0);
      step();
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
    check("drain", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b1; in_last = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    imem_ack = 1'b1;
    start2 = 1'b0; base2 = '0; valid2 = 1'b0; ack2 = 1'b1;

    // reset held 2 cycles with in_valid high
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_wen", imem_wen, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_state", dbg_state, 0);
    step();
    rst = 1'b1;
    in_valid = 1'b0;
    step();

    // arithmetic stream, ack high
    do_start(8'h10);
    send(LD_OP_ADD,  5'd1, 5'd2, 5'd3, 16'h0000, 26'h0, 1'b0, 32'h00221820);
    send(LD_OP_ADDI, 5'd0, 5'd1, 5'd0, 16'h0005, 26'h0, 1'b0, 32'h20010005);
    send(LD_OP_ORI,  5'd1, 5'd1, 5'd0, 16'hFFFF, 26'h0, 1'b1, 32'h3421FFFF);
    drain();
    @(negedge clk);
    check("arith_done", done, 1);
    check("arith_count", count, 3);
    check("arith_busy", busy, 0);
    check("arith_state", dbg_state, 3'd3);
    check("arith_addr", imem_addr, 8'h13);
    step();

    // memory / branch / jump encodings
    do_start(8'h40);
    send(LD_OP_LW,  5'd1,  5'd2, 5'd0, 16'h0004, 26'h0,  1'b0, 32'h8C220004);
    send(LD_OP_SW,  5'd1,  5'd2, 5'd0, 16'h0008, 26'h0,  1'b0, 32'hAC220008);
    send(LD_OP_BEQ, 5'd1,  5'd2, 5'd0, 16'hFFFF, 26'h0,  1'b0, 32'h1022FFFF);
    send(LD_OP_J,   5'd3,  5'd4, 5'd5, 16'h1234, 26'h10, 1'b0, 32'h08000010);
    send(LD_OP_JAL, 5'd0,  5'd0, 5'd0, 16'h0000, 26'h10, 1'b0, 32'h0C000010);
    send(LD_OP_SUB, 5'd4,  5'd5, 5'd6, 16'h0000, 26'h0,  1'b0, 32'h00853022);
    send(LD_OP_NOP, 5'd7,  5'd8, 5'd9, 16'hABCD, 26'h3,  1'b0, 32'h00000000);
    send(LD_OP_JR,  5'd31, 5'd7, 5'd9, 16'h0000, 26'h0,  1'b1, 32'h03E00008);
    drain();
    @(negedge clk);
    check("enc_done", done, 1);
    check("enc_count", count, 8);
    step();

    // backpressure, with address wrap 0xFF -> 0x00
    do_start(8'hFE);
    imem_ack = 1'b0;
    send(LD_OP_AND, 5'd2, 5'd3, 5'd4, 16'h0000, 26'h0, 1'b0, 32'h00432024);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_wen", imem_wen, 1);
      check("bp_addr", imem_addr, 8'hFE);
      check("bp_data", imem_wdata, 32'h00432024);
      check("bp_ready", in_ready, 0);
      step();
    end
    imem_ack = 1'b1;
    step();
    @(negedge clk);
    check("bp_addr_adv", imem_addr, 8'hFF);
    check("bp_count", count, 1);
    check("bp_ready_back", in_ready, 1);
    step();
    send(LD_OP_ANDI, 5'd1, 5'd2, 5'd0, 16'h00F0, 26'h0, 1'b0, 32'h302200F0);
    send(LD_OP_SLT,  5'd1, 5'd2, 5'd3, 16'h0000, 26'h0, 1'b1, 32'h0022182A);
    drain();
    @(negedge clk);
    check("wrap_addr", imem_addr, 8'h01);
    check("wrap_done", done, 1);
    step();

    // illegal op
    do_start(8'h00);
    send(LD_OP_OR,  5'd1, 5'd2, 5'd3, 16'h0000, 26'h0, 1'b0, 32'h00221825);
    send(LD_OP_ILL, 5'd1, 5'd2, 5'd3, 16'h0000, 26'h0, 1'b0, 32'h0);
    @(negedge clk);
    check("ill_err", err, 1);
    check("ill_wen", imem_wen, 0);
    check("ill_count", count, 1);
    check("ill_state", dbg_state, 3'd4);
    check("ill_done", done, 0);
    step();

    // overflow on the 4-word instance, base 3
    start2 = 1'b1; base2 = 2'd3;
    step();
    start2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bit got;
      got = 0;
      in_op = LD_OP_ADDI; in_rs = 5'd0; in_rt = 5'(k); in_imm = 16'(k); in_last = 1'b0;
      valid2 = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (ready2) begin got = 1; break; end
        step();
      end
      check("ovf_hs", got, 1);
      step();
      valid2 = 1'b0;
      @(negedge clk);
      check("ovf_wen", wen2, 1);
      check("ovf_addr", addr2, 64'((3 + k) % 4));
      check("ovf_data", wdata2, ref_encode(LD_OP_ADDI, 5'd0, 5'(k), 5'd0, 16'(k), 26'h0));
      step();
    end
    @(negedge clk);
    check("ovf_err", err2, 1);
    check("ovf_count", count2, 4);
    check("ovf_state", state2, 3'd4);
    step();
    valid2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ovf_no_ready", ready2, 0);
      check("ovf_no_wen", wen2, 0);
      step();
    end
    valid2 = 1'b0;

    // mid-session reset while stalled in WRITE
    do_start(8'h20);
    imem_ack = 1'b0;
    send(LD_OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0000, 26'h0, 1'b0, 32'h00221820);
    rst = 1'b0;
    step();
    @(negedge clk);
    check("mrst_wen", imem_wen, 0);
    check("mrst_count", count, 0);
    check("mrst_state", dbg_state, 3'd0);
    check("mrst_busy", busy, 0);
    exp_q.delete();
    model_cnt = 0;
    step();
    rst = 1'b1;
    imem_ack = 1'b1;
    step();
    do_start(8'h30);
    send(LD_OP_ADDI, 5'd0, 5'd1, 5'd0, 16'h0005, 26'h0, 1'b1, 32'h20010005);
    drain();
    @(negedge clk);
    check("post_done", done, 1);
    check("post_count", count, 1);
    check("post_addr", imem_addr, 8'h31);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
